// File: rtl/fetch_ctrl_if.sv
// Bundle of signals between the IF stage sequencer and the surrounding pipeline:
// instruction memory, hazard/redirect inputs and the IF/ID register outputs.
interface fetch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             stall;
  logic             br_valid;
  logic [31:0]      br_target;
  logic             jmp_valid;
  logic [31:0]      jmp_target;
  logic [31:0]      if_id_inst;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic             fault;
  logic [31:0]      fault_pc;
  logic [CNT_W-1:0] fetch_cnt;

  // Fetch stage side.
  modport master (
    input  start, imem_data, stall, br_valid, br_target, jmp_valid, jmp_target,
    output imem_addr, if_id_inst, if_id_pc4, if_id_valid, fault, fault_pc, fetch_cnt
  );

  // Pipeline / memory side.
  modport slave (
    output start, imem_data, stall, br_valid, br_target, jmp_valid, jmp_target,
    input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, fault, fault_pc, fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the IF/ID register and applies
// stall, branch/jump redirects and misaligned-target trapping.
module fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFault = 2'd2;

  localparam logic [31:0]      AddrMask = 32'(MEM_BYTES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_mem_bytes
    $error("fetch_ctrl: MEM_BYTES must be a power of two and at least 4");
  end
  if ((RESET_PC[1:0] != 2'b00) || (RESET_PC >= 32'(MEM_BYTES))) begin : g_bad_reset_pc
    $error("fetch_ctrl: RESET_PC must be word aligned and inside the memory");
  end

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] seq_pc;
  logic        br_misaligned;
  logic        jmp_misaligned;

  assign seq_pc         = (pc_q + 32'd4) & AddrMask;
  assign br_misaligned  = (bus.br_target[1:0] != 2'b00);
  assign jmp_misaligned = (bus.jmp_target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;

    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (bus.start) begin
          state_d = StRun;
        end
      end

      StRun: begin
        // The branch is older than the jump in ID, so it takes priority.
        if (bus.br_valid) begin
          valid_d = 1'b0;
          if (br_misaligned) begin
            state_d    = StFault;
            fault_d    = 1'b1;
            fault_pc_d = bus.br_target;
          end else begin
            pc_d = bus.br_target & AddrMask;
          end
        end else if (bus.jmp_valid) begin
          valid_d = 1'b0;
          if (jmp_misaligned) begin
            state_d    = StFault;
            fault_d    = 1'b1;
            fault_pc_d = bus.jmp_target;
          end else begin
            pc_d = bus.jmp_target & AddrMask;
          end
        end else if (!bus.stall) begin
          inst_d  = bus.imem_data;
          pc4_d   = seq_pc;
          valid_d = 1'b1;
          pc_d    = seq_pc;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StFault: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes the expected post-edge state,
// a monitor on the falling edge pops and compares it.
module tb_fetch_ctrl;

  localparam int unsigned CW = 3;

  typedef struct {
    logic [31:0]   pc;
    logic          valid;
    logic [31:0]   pc4;
    logic [31:0]   inst;
    logic          fault;
    logic [31:0]   fpc;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  fetch_ctrl_if #(.CNT_W(CW)) bus ();

  fetch_ctrl #(
    .MEM_BYTES(256),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Word 0 is the loop program's first instruction; others encode their word index.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h8FE1_0001;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.imem_data = word_at(bus.imem_addr);

  function automatic exp_t mk(input logic [31:0] pc, input logic v, input logic [31:0] pc4,
                              input logic [31:0] inst, input logic f, input logic [31:0] fpc,
                              input logic [CW-1:0] cnt);
    exp_t e;
    e.pc = pc; e.valid = v; e.pc4 = pc4; e.inst = inst;
    e.fault = f; e.fpc = fpc; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string name, input int vec, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %h, expected %h", vec, name, act, exp);
    end
  endtask

  int n_chk = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      chk("imem_addr", n_chk, bus.imem_addr, e.pc);
      chk("if_id_valid", n_chk, 32'(bus.if_id_valid), 32'(e.valid));
      chk("if_id_pc4", n_chk, bus.if_id_pc4, e.pc4);
      chk("if_id_inst", n_chk, bus.if_id_inst, e.inst);
      chk("fault", n_chk, 32'(bus.fault), 32'(e.fault));
      chk("fault_pc", n_chk, bus.fault_pc, e.fpc);
      chk("fetch_cnt", n_chk, 32'(bus.fetch_cnt), 32'(e.cnt));
    end
  end

  task automatic step(input logic r, input logic st, input logic sl, input logic bv,
                      input logic [31:0] bt, input logic jv, input logic [31:0] jt,
                      input exp_t e);
    @(negedge clk);
    #1;
    rst = r; bus.start = st; bus.stall = sl;
    bus.br_valid = bv; bus.br_target = bt;
    bus.jmp_valid = jv; bus.jmp_target = jt;
    exp_q.push_back(e);
    n_vec++;
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0;
    bus.br_valid = 1'b0; bus.br_target = '0;
    bus.jmp_valid = 1'b0; bus.jmp_target = '0;

    step(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    // IDLE ignores everything but start.
    step(0, 0, 1, 1, 32'h0E, 1, 32'h10, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, mk(4, 1, 4, 32'h8FE1_0001, 0, 0, 1));
    step(0, 0, 0, 0, 0, 0, 0, mk(8, 1, 8, word_at(4), 0, 0, 2));
    step(0, 0, 0, 0, 0, 0, 0, mk(12, 1, 12, word_at(8), 0, 0, 3));
    step(0, 0, 0, 0, 0, 0, 0, mk(16, 1, 16, word_at(12), 0, 0, 4));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, mk(16, 1, 16, word_at(12), 0, 0, 4));
    end
    step(0, 0, 0, 0, 0, 0, 0, mk(20, 1, 20, word_at(16), 0, 0, 5));
    step(0, 0, 0, 0, 0, 0, 0, mk(24, 1, 24, word_at(20), 0, 0, 6));
    step(0, 0, 0, 0, 0, 0, 0, mk(28, 1, 28, word_at(24), 0, 0, 7));
    // Jump from 28 to 12: bubble, IF/ID data untouched.
    step(0, 0, 0, 0, 0, 1, 32'd12, mk(12, 0, 28, word_at(24), 0, 0, 7));
    // Counter saturates at 7 with CNT_W=3.
    step(0, 0, 0, 0, 0, 0, 0, mk(16, 1, 16, word_at(12), 0, 0, 7));
    // Branch beats jump and stall.
    step(0, 0, 1, 1, 32'd28, 1, 32'd12, mk(28, 0, 16, word_at(12), 0, 0, 7));
    step(0, 0, 0, 0, 0, 0, 0, mk(32, 1, 32, word_at(28), 0, 0, 7));
    step(0, 0, 0, 1, 32'hFC, 0, 0, mk(252, 0, 32, word_at(28), 0, 0, 7));
    // Sequential wrap from 252 to 0.
    step(0, 0, 0, 0, 0, 0, 0, mk(0, 1, 0, word_at(252), 0, 0, 7));
    // Jump target masked: 0x104 -> 4.
    step(0, 0, 0, 0, 0, 1, 32'h104, mk(4, 0, 0, word_at(252), 0, 0, 7));
    step(0, 0, 0, 0, 0, 0, 0, mk(8, 1, 8, word_at(4), 0, 0, 7));
    // Misaligned branch traps even with a jump present.
    step(0, 0, 0, 1, 32'h0E, 1, 32'h10, mk(8, 0, 8, word_at(4), 1, 32'h0E, 7));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 32'h20, 1, 32'h10, mk(8, 0, 8, word_at(4), 1, 32'h0E, 7));
    end
    step(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, mk(4, 1, 4, 32'h8FE1_0001, 0, 0, 1));
    // Misaligned jump: fault_pc keeps the unmasked target.
    step(0, 0, 0, 0, 0, 1, 32'h8000_0102, mk(4, 0, 4, 32'h8FE1_0001, 1, 32'h8000_0102, 1));
    step(1, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, mk(4, 1, 4, 32'h8FE1_0001, 0, 0, 1));
    // Reset while running.
    step(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        n_miss++;
        $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
